switch_arbiter: RTL and testbench

SWITCH_ARBITER -- requirements
Module: switch_arbiter

---
 rtl/switch_arbiter_pkg.sv | 15 +
 rtl/switch_arbiter_if.sv | 31 +++
 rtl/switch_arbiter_rr_pick.sv | 33 +++
 rtl/switch_arbiter.sv | 122 ++++++++++++
 tb/tb_switch_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_arbiter_pkg.sv
// Shared types and defaults for the switch arbiter slice.
// FSM encoding and default geometry live here.
package switch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int AW_DEV_DEF   = 2;
    localparam int DW_DEF       = 4;
    localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/switch_arbiter_if.sv
// Arbiter request/grant bundle between sources, FIFOs and arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface switch_arbiter_if
    import switch_arbiter_pkg::*;
#(
    parameter int AW_DEV = AW_DEV_DEF
) ();

    localparam int N_PORT = 1 << AW_DEV;

    logic                     en_i;
    logic [N_PORT-1:0]        req_i;
    logic [N_PORT*AW_DEV-1:0] adr_i;
    logic [N_PORT-1:0]        full_array;
    logic [N_PORT-1:0]        gnt;
    logic [N_PORT-1:0]        wen;
    logic [AW_DEV-1:0]        sel_o;
    logic                     busy_o;
    logic [N_PORT-1:0]        starve_o;

    modport slave (
        input  en_i, req_i, adr_i, full_array,
        output gnt, wen, sel_o, busy_o, starve_o
    );

    modport master (
        output en_i, req_i, adr_i, full_array,
        input  gnt, wen, sel_o, busy_o, starve_o
    );

endinterface

// File: rtl/switch_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches ptr+1, ptr+2, ... wrapping, and reports the first set request.
module rr_pick #(
    parameter int AW = 2
) (
    input  logic [(1<<AW)-1:0] req_i,
    input  logic [AW-1:0]      ptr_i,
    output logic [(1<<AW)-1:0] gnt_o,
    output logic [AW-1:0]      idx_o,
    output logic               vld_o
);

    localparam int N = 1 << AW;

    logic [AW-1:0] cand;

    // First requester after the pointer wins; index arithmetic wraps in AW bits.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr_i + AW'(k);
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
        gnt_o[idx_o] = vld_o;
    end

endmodule

// File: rtl/switch_arbiter.sv
// Crossbar write arbiter: one grant per IDLE->GRANT->GAP round.
// Sources whose destination FIFO is full are skipped, never stalled.
module switch_arbiter
    import switch_arbiter_pkg::*;
#(
    parameter int AW_DEV   = AW_DEV_DEF,
    parameter int DW       = DW_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    switch_arbiter_if.slave   bus
);

    localparam int N_PORT = 1 << AW_DEV;
    localparam int CW     = $clog2(WAIT_MAX + 1);

    if (DW < 1) begin : g_dw_chk
        $error("DW must be at least 1");
    end

    state_t              state_q, state_d;
    logic [N_PORT-1:0]   gnt_q, gnt_d;
    logic [N_PORT-1:0]   wen_q, wen_d;
    logic [AW_DEV-1:0]   sel_q, sel_d;
    logic [AW_DEV-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]       wait_q [N_PORT];

    logic [N_PORT-1:0]   elig;
    logic [N_PORT-1:0]   pick_oh;
    logic [AW_DEV-1:0]   pick_idx;
    logic                pick_vld;
    logic [AW_DEV-1:0]   pick_dst;

    // A source is eligible when it requests and its target FIFO has room.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_PORT; i++) begin
            elig[i] = bus.req_i[i] & bus.en_i
                    & ~bus.full_array[bus.adr_i[i*AW_DEV +: AW_DEV]];
        end
    end

    rr_pick #(
        .AW (AW_DEV)
    ) u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign pick_dst = bus.adr_i[pick_idx*AW_DEV +: AW_DEV];

    // Next state and next registered outputs; grants only start from IDLE.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        wen_d   = '0;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d         = GRANT;
                    gnt_d           = pick_oh;
                    wen_d[pick_dst] = 1'b1;
                    sel_d           = pick_idx;
                    ptr_d           = pick_idx;
                end
            end
            GRANT:   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; pointer resets so source 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wen_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= AW_DEV'(N_PORT - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // Per-source wait counters, saturating at the starvation threshold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_PORT; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_PORT; i++) begin
                if (!bus.req_i[i] || gnt_q[i])
                    wait_q[i] <= '0;
                else if (wait_q[i] != CW'(WAIT_MAX))
                    wait_q[i] <= wait_q[i] + 1'b1;
            end
        end
    end

    // Starvation flags come straight from the counters.
    always_comb begin
        bus.starve_o = '0;
        for (int i = 0; i < N_PORT; i++)
            bus.starve_o[i] = (wait_q[i] == CW'(WAIT_MAX));
    end

    assign bus.gnt    = gnt_q;
    assign bus.wen    = wen_q;
    assign bus.sel_o  = sel_q;
    assign bus.busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: vector table, corner sequences, random vs model.
// The model tracks a phase counter and plain integer wait counts.
module tb_switch_arbiter;

    localparam int AW  = 2;
    localparam int NP  = 4;
    localparam int WM  = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    switch_arbiter_if #(.AW_DEV(AW)) bus ();

    switch_arbiter #(
        .AW_DEV   (AW),
        .DW       (4),
        .WAIT_MAX (WM)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] adr;
        logic [3:0] full;
        logic       en;
        logic [3:0] gnt;
        logic [3:0] wen;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs [7];

    int         m_phase;
    int         m_ptr;
    logic [3:0] m_gnt;
    logic [3:0] m_wen;
    int         m_sel;
    int         m_wait [NP];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [7:0] a,
                          input logic [3:0] f, input logic e);
        bus.req_i      = r;
        bus.adr_i      = a;
        bus.full_array = f;
        bus.en_i       = e;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = NP - 1;
        m_gnt   = '0;
        m_wen   = '0;
        m_sel   = 0;
        for (int i = 0; i < NP; i++) m_wait[i] = 0;
    endtask

    task automatic do_reset(input bit check_it);
        rst_n = 1'b0;
        set_in(4'h0, 8'h00, 4'h0, 1'b0);
        model_reset();
        #12;
        if (check_it) begin
            chk("rst_gnt", 32'(bus.gnt), 32'h0);
            chk("rst_wen", 32'(bus.wen), 32'h0);
            chk("rst_sel", 32'(bus.sel_o), 32'h0);
            chk("rst_busy", 32'(bus.busy_o), 32'h0);
            chk("rst_starve", 32'(bus.starve_o), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_step();
        logic [3:0] old_gnt;
        int         c;
        int         d;
        bit         found;
        old_gnt = m_gnt;
        for (int i = 0; i < NP; i++) begin
            if (!bus.req_i[i] || old_gnt[i]) m_wait[i] = 0;
            else if (m_wait[i] < WM) m_wait[i] = m_wait[i] + 1;
        end
        m_gnt = '0;
        m_wen = '0;
        if (m_phase == 0) begin
            found = 0;
            for (int k = 1; k <= NP; k++) begin
                c = (m_ptr + k) % NP;
                d = (bus.adr_i >> (2 * c)) & 3;
                if (!found && bus.en_i && bus.req_i[c] && !bus.full_array[d]) begin
                    found = 1;
                    m_gnt = 4'(1 << c);
                    m_wen = 4'(1 << d);
                    m_sel = c;
                    m_ptr = c;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sv;
        checks = 0;
        errors = 0;

        vecs[0] = '{4'b1111, 8'h00, 4'b0000, 1'b1, 4'b0001, 4'b0001, 2'd0};
        vecs[1] = '{4'b0110, 8'h0C, 4'b1000, 1'b1, 4'b0100, 4'b0001, 2'd2};
        vecs[2] = '{4'b1000, 8'hC0, 4'b0000, 1'b1, 4'b1000, 4'b1000, 2'd3};
        vecs[3] = '{4'b0010, 8'h08, 4'b0100, 1'b1, 4'b0000, 4'b0000, 2'd0};
        vecs[4] = '{4'b1111, 8'h00, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[5] = '{4'b1010, 8'h04, 4'b0000, 1'b1, 4'b0010, 4'b0010, 2'd1};
        vecs[6] = '{4'b1100, 8'hB0, 4'b1000, 1'b1, 4'b1000, 4'b0100, 2'd3};

        for (int v = 0; v < 7; v++) begin
            do_reset(v == 0);
            set_in(vecs[v].req, vecs[v].adr, vecs[v].full, vecs[v].en);
            step();
            chk($sformatf("vec%0d_gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
            chk($sformatf("vec%0d_wen", v), 32'(bus.wen), 32'(vecs[v].wen));
            chk($sformatf("vec%0d_sel", v), 32'(bus.sel_o), 32'(vecs[v].sel));
            chk($sformatf("vec%0d_busy", v), 32'(bus.busy_o),
                32'(vecs[v].gnt != 0));
        end

        do_reset(0);
        set_in(4'b1111, 8'h00, 4'b0000, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            step();
            sv = (c % 3 == 1) ? 4'(1 << (((c - 1) / 3) % 4)) : 4'b0000;
            chk($sformatf("rr_gnt_c%0d", c), 32'(bus.gnt), 32'(sv));
            chk($sformatf("rr_wen_c%0d", c), 32'(bus.wen),
                (sv != 0) ? 32'h1 : 32'h0);
        end

        do_reset(0);
        set_in(4'b0110, 8'h0C, 4'b1000, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("blk_gnt_c%0d", c), 32'(bus.gnt),
                (c % 3 == 1) ? 32'h4 : 32'h0);
            if (c % 3 == 1) begin
                chk("blk_sel", 32'(bus.sel_o), 32'h2);
                chk("blk_wen", 32'(bus.wen), 32'h1);
            end
        end

        do_reset(0);
        set_in(4'b0001, 8'h00, 4'b0000, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            step();
            chk($sformatf("en0_gnt_c%0d", c), 32'(bus.gnt), 32'h0);
            chk($sformatf("en0_starve_c%0d", c), 32'(bus.starve_o[0]),
                32'(c >= 15));
        end
        bus.en_i = 1'b1;
        step();
        chk("en1_gnt", 32'(bus.gnt), 32'h1);
        step();
        chk("en1_starve_clr", 32'(bus.starve_o), 32'h0);
        chk("en1_gap_gnt", 32'(bus.gnt), 32'h0);

        do_reset(0);
        set_in(4'b1111, 8'h00, 4'b0000, 1'b1);
        step();
        chk("arst_pre_gnt", 32'(bus.gnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'h0);
        chk("arst_wen", 32'(bus.wen), 32'h0);
        chk("arst_busy", 32'(bus.busy_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_again_gnt", 32'(bus.gnt), 32'h1);

        do_reset(0);
        set_in(4'b1000, 8'hC0, 4'b0000, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("solo_gnt_c%0d", c), 32'(bus.gnt),
                (c % 3 == 1) ? 32'h8 : 32'h0);
            chk($sformatf("solo_busy_c%0d", c), 32'(bus.busy_o),
                32'(c % 3 != 0));
        end

        do_reset(0);
        for (int c = 0; c < 600; c++) begin
            set_in(4'($urandom), 8'($urandom),
                   4'($urandom) & 4'($urandom),
                   ($urandom_range(0, 9) != 0));
            if (c >= 200 && c < 260) bus.en_i = 1'b0;
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_gnt", 32'(bus.gnt), 32'(m_gnt));
            chk("rnd_wen", 32'(bus.wen), 32'(m_wen));
            chk("rnd_sel", 32'(bus.sel_o), 32'(m_sel));
            chk("rnd_busy", 32'(bus.busy_o), 32'(m_phase != 0));
            for (int i = 0; i < NP; i++)
                chk("rnd_starve", 32'(bus.starve_o[i]), 32'(m_wait[i] == WM));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
